proc_control_unit: RTL and testbench

Control FSM for the Lab9 simple processor. It fetches a 9-bit instruction from DIN and sequences it over timesteps T0..T3. It drives the register-write select (RIN_SEL/RIN_EN) and the bus-source select (ROUT_SEL/ROUT_EN). Each select pair feeds a 3-to-8 DECODER instance as LINEIN/EN, so this block sits directly upstream of the register-select decoders.

---
 rtl/proc_control_unit.sv | 131 +++++++++++++
 tb/tb_proc_control_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_control_unit.sv
// Control FSM for the simple processor: fetches a 9-bit instruction and
// sequences mv/mvi/add/sub over timesteps T0..T3.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   run             start request, sampled only in T0
//   din[DW-1:0]     instruction/immediate bus (only din[8:0] is used)
//   ir[8:0]         latched instruction III XXX YYY
//   rin_sel/rin_en  destination register code and decoder enable
//   rout_sel/rout_en source register code and decoder enable
//   dinout, ain, gin, gout, addsub, done   datapath controls
//   state[1:0]      current timestep T0=00 .. T3=11
module proc_control_unit #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [DW-1:0] din,
    output logic [8:0]    ir,
    output logic [2:0]    rin_sel,
    output logic          rin_en,
    output logic [2:0]    rout_sel,
    output logic          rout_en,
    output logic          dinout,
    output logic          ain,
    output logic          gin,
    output logic          gout,
    output logic          addsub,
    output logic          done,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t     cur;
    state_t     nxt;
    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;

    assign op    = ir[8:6];
    assign rx    = ir[5:3];
    assign ry    = ir[2:0];
    assign state = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= T0;
            ir  <= '0;
        end else begin
            cur <= nxt;
            if (cur == T0 && run) begin
                ir <= din[8:0];
            end
        end
    end

    always_comb begin
        nxt      = T0;
        rin_sel  = 3'b000;
        rin_en   = 1'b0;
        rout_sel = 3'b000;
        rout_en  = 1'b0;
        dinout   = 1'b0;
        ain      = 1'b0;
        gin      = 1'b0;
        gout     = 1'b0;
        addsub   = 1'b0;
        done     = 1'b0;
        case (cur)
            T0: begin
                nxt = run ? T1 : T0;
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        rout_en  = 1'b1;
                        rout_sel = ry;
                        rin_en   = 1'b1;
                        rin_sel  = rx;
                        done     = 1'b1;
                    end
                    OP_MVI: begin
                        dinout  = 1'b1;
                        rin_en  = 1'b1;
                        rin_sel = rx;
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_en  = 1'b1;
                        rout_sel = rx;
                        ain      = 1'b1;
                        nxt      = T2;
                    end
                    default: begin
                        done = 1'b1;
                    end
                endcase
            end
            T2: begin
                rout_en  = 1'b1;
                rout_sel = ry;
                gin      = 1'b1;
                // opcode LSB distinguishes sub (011) from add (010)
                addsub   = ir[6];
                nxt      = T3;
            end
            T3: begin
                gout    = 1'b1;
                rin_en  = 1'b1;
                rin_sel = rx;
                done    = 1'b1;
            end
            default: begin
                nxt = T0;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed self-checking bench for proc_control_unit.
// Control vector: {rin_en, rin_sel, rout_en, rout_sel, dinout, ain, gin, gout, addsub, done}
module tb_proc_control_unit;

    logic       clk;
    logic       reset;
    logic       run;
    logic [8:0] din;
    logic [8:0] ir;
    logic [2:0] rin_sel;
    logic       rin_en;
    logic [2:0] rout_sel;
    logic       rout_en;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       addsub;
    logic       done;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [13:0] ctl;
    logic [1:0]  drivers;
    assign ctl = {rin_en, rin_sel, rout_en, rout_sel,
                  dinout, ain, gin, gout, addsub, done};
    assign drivers = 2'(rout_en) + 2'(dinout) + 2'(gout);

    proc_control_unit #(.DW(9)) dut (
        .clk(clk), .reset(reset), .run(run), .din(din),
        .ir(ir), .rin_sel(rin_sel), .rin_en(rin_en),
        .rout_sel(rout_sel), .rout_en(rout_en), .dinout(dinout),
        .ain(ain), .gin(gin), .gout(gout), .addsub(addsub),
        .done(done), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b0;
        din   = 9'h1FF;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (state !== 2'b00 || ir !== 9'd0 || ctl !== 14'd0) begin
                n_bad++;
                $display("FAIL reset_idle cyc%0d: state=%b ir=%b ctl=%b, want 00 000000000 0",
                         i, state, ir, ctl);
            end
            tick();
        end
    endtask

    task automatic test_mv();
        din = 9'b000_011_101;
        run = 1'b1;
        tick();
        run = 1'b0;
        din = 9'h155;
        n_cmp++;
        if (state !== 2'b01 ||
            ctl !== {1'b1, 3'b011, 1'b1, 3'b101, 6'b000001}) begin
            n_bad++;
            $display("FAIL mv_t1: state=%b ctl=%b, want 01 %b",
                     state, ctl, {1'b1, 3'b011, 1'b1, 3'b101, 6'b000001});
        end
        tick();
        n_cmp++;
        if (state !== 2'b00 || ctl !== 14'd0) begin
            n_bad++;
            $display("FAIL mv_back_t0: state=%b ctl=%b, want 00 0", state, ctl);
        end
    endtask

    task automatic test_mvi();
        din = 9'b001_110_000;
        run = 1'b1;
        tick();
        run = 1'b0;
        din = 9'h0AB;
        n_cmp++;
        if (state !== 2'b01 || ir !== 9'b001110000 ||
            ctl !== {1'b1, 3'b110, 1'b0, 3'b000, 6'b100001}) begin
            n_bad++;
            $display("FAIL mvi_t1: state=%b ir=%b ctl=%b, want 01 001110000 %b",
                     state, ir, ctl, {1'b1, 3'b110, 1'b0, 3'b000, 6'b100001});
        end
        tick();
        n_cmp++;
        if (state !== 2'b00 || ir !== 9'b001110000) begin
            n_bad++;
            $display("FAIL mvi_back_t0: state=%b ir=%b, want 00 001110000", state, ir);
        end
    endtask

    task automatic test_sub();
        din = 9'b011_010_111;
        run = 1'b1;
        tick();
        run = 1'b0;
        din = 9'b000_000_001;
        n_cmp++;
        if (state !== 2'b01 ||
            ctl !== {1'b0, 3'b000, 1'b1, 3'b010, 6'b010000}) begin
            n_bad++;
            $display("FAIL sub_t1: state=%b ctl=%b", state, ctl);
        end
        tick();
        n_cmp++;
        if (state !== 2'b10 ||
            ctl !== {1'b0, 3'b000, 1'b1, 3'b111, 6'b001010}) begin
            n_bad++;
            $display("FAIL sub_t2: state=%b ctl=%b", state, ctl);
        end
        tick();
        n_cmp++;
        if (state !== 2'b11 ||
            ctl !== {1'b1, 3'b010, 1'b0, 3'b000, 6'b000101}) begin
            n_bad++;
            $display("FAIL sub_t3: state=%b ctl=%b", state, ctl);
        end
        tick();
        n_cmp++;
        if (state !== 2'b00 || ctl !== 14'd0) begin
            n_bad++;
            $display("FAIL sub_back_t0: state=%b ctl=%b, want 00 0", state, ctl);
        end
        tick();
        n_cmp++;
        if (state !== 2'b00 || ir !== 9'b011010111) begin
            n_bad++;
            $display("FAIL sub_idle_hold: state=%b ir=%b, want 00 011010111", state, ir);
        end
    endtask

    task automatic test_add_reset();
        din = 9'b010_001_001;
        run = 1'b1;
        tick();
        run = 1'b0;
        n_cmp++;
        if (state !== 2'b01 ||
            ctl !== {1'b0, 3'b000, 1'b1, 3'b001, 6'b010000}) begin
            n_bad++;
            $display("FAIL add_t1: state=%b ctl=%b", state, ctl);
        end
        tick();
        n_cmp++;
        if (state !== 2'b10 ||
            ctl !== {1'b0, 3'b000, 1'b1, 3'b001, 6'b001000}) begin
            n_bad++;
            $display("FAIL add_t2: state=%b ctl=%b", state, ctl);
        end
        reset = 1'b1;
        run   = 1'b1;
        tick();
        reset = 1'b0;
        run   = 1'b0;
        n_cmp++;
        if (state !== 2'b00 || ir !== 9'd0 || gin !== 1'b0 || ctl !== 14'd0) begin
            n_bad++;
            $display("FAIL add_reset: state=%b ir=%b ctl=%b, want 00 0 0", state, ir, ctl);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (done !== 1'b0 || state !== 2'b00) begin
                n_bad++;
                $display("FAIL add_reset_nodone cyc%0d: done=%b state=%b, want 0 00",
                         i, done, state);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] done_seen;
        done_seen = 4'b0000;
        din = 9'b000_011_101;
        run = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 0) din = 9'b111_000_000;
            done_seen[c] = done;
            n_cmp++;
            if (drivers > 2'd1) begin
                n_bad++;
                $display("FAIL b2b_bus cyc%0d: drivers=%0d, want <=1", c, drivers);
            end
            if (c == 2) begin
                n_cmp++;
                if (state !== 2'b01 || ir !== 9'b111000000 ||
                    ctl !== 14'b00000000000001) begin
                    n_bad++;
                    $display("FAIL nop_t1: state=%b ir=%b ctl=%b, want 01 111000000 1",
                             state, ir, ctl);
                end
            end
        end
        run = 1'b0;
        n_cmp++;
        if (done_seen !== 4'b0101) begin
            n_bad++;
            $display("FAIL b2b_done: pattern=%b, want 0101", done_seen);
        end
    endtask

    initial begin
        reset = 1'b0;
        run   = 1'b0;
        din   = 9'd0;
        test_reset();
        test_mv();
        test_mvi();
        test_sub();
        test_add_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
